// File: rtl/prog_clockgen.sv
// Programmable multi-channel clock-enable generator. Each channel emits a one-cycle pulse every div_active+1 cycles.
// Latency: the first pulse is registered on the (div_active+1)-th edge that samples run=1. Outputs are registered.
// Backpressure: none. Divisor writes are staged in a shadow register and promoted at the next terminal count, or at once when stopped.
module prog_clockgen #(
    parameter int NCH       = 4,
    parameter int DIVW      = 18,
    parameter int SELW      = 2,
    parameter int RESET_DIV = 200000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NCH-1:0]  run,
    input  logic [NCH-1:0]  oneshot,
    input  logic            sync,
    input  logic            div_wr,
    input  logic [SELW-1:0] div_sel,
    input  logic [DIVW-1:0] div_data,
    output logic [NCH-1:0]  clocken,
    output logic [NCH-1:0]  done
);

    localparam logic [DIVW-1:0] RST_DIV = DIVW'(RESET_DIV);

    // Per-channel state
    logic [DIVW-1:0] cnt_q      [NCH];
    logic [DIVW-1:0] cnt_d      [NCH];
    logic [DIVW-1:0] act_q      [NCH];
    logic [DIVW-1:0] act_d      [NCH];
    logic [DIVW-1:0] shd_q      [NCH];
    logic [DIVW-1:0] shd_d      [NCH];
    logic [DIVW-1:0] load_val   [NCH];
    logic [NCH-1:0]  wr_hit;
    logic [NCH-1:0]  armed_q;
    logic [NCH-1:0]  armed_d;
    logic [NCH-1:0]  clocken_d;
    logic [NCH-1:0]  done_d;

    // Decode the divisor write. An out-of-range select matches no channel.
    // A write landing on a reload edge bypasses the shadow so that its data is what gets loaded.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i]   = div_wr && (int'(div_sel) == i);
            load_val[i] = wr_hit[i] ? div_data : shd_q[i];
        end
    end

    // Next-state logic per channel. Priority is sync, then stopped, then disarmed, then counting.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]     = cnt_q[i];
            act_d[i]     = act_q[i];
            shd_d[i]     = load_val[i];
            armed_d[i]   = armed_q[i];
            clocken_d[i] = 1'b0;
            done_d[i]    = done[i];

            if (sync || !run[i]) begin
                // Restart the channel phase-aligned and pick up any pending divisor.
                cnt_d[i]   = '0;
                act_d[i]   = load_val[i];
                armed_d[i] = 1'b1;
                done_d[i]  = 1'b0;
            end else if (!armed_q[i]) begin
                // Oneshot has fired. Park at zero until run is dropped.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == act_q[i]) begin
                // Terminal count. Pulse, then promote the shadow divisor for the next period.
                cnt_d[i]     = '0;
                act_d[i]     = load_val[i];
                clocken_d[i] = 1'b1;
                if (oneshot[i]) begin
                    armed_d[i] = 1'b0;
                    done_d[i]  = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + DIVW'(1);
            end
        end
    end

    // State register with synchronous reset. Reset overrides every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= RST_DIV;
                shd_q[i] <= RST_DIV;
            end
            armed_q <= '1;
            clocken <= '0;
            done    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
            end
            armed_q <= armed_d;
            clocken <= clocken_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_prog_clockgen.sv
// Bench for prog_clockgen with NCH=4, DIVW=8, SELW=3, RESET_DIV=4.
// A pulse-schedule model is checked on every cycle, and directed scenarios check literal edge counts.
// Inputs are driven on the falling edge, and the outputs are sampled on the falling edge.
module tb_prog_clockgen;

    localparam int NCH  = 4;
    localparam int DIVW = 8;
    localparam int SELW = 3;
    localparam int RDIV = 4;

    logic            clock;
    logic            reset;
    logic [NCH-1:0]  run;
    logic [NCH-1:0]  oneshot;
    logic            sync;
    logic            div_wr;
    logic [SELW-1:0] div_sel;
    logic [DIVW-1:0] div_data;
    logic [NCH-1:0]  clocken;
    logic [NCH-1:0]  done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    prog_clockgen #(
        .NCH(NCH), .DIVW(DIVW), .SELW(SELW), .RESET_DIV(RDIV)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .oneshot(oneshot), .sync(sync),
        .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
        .clocken(clocken), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: each channel keeps the absolute edge number of its next pulse.
    // Divisor changes only move that schedule when a pulse fires or when the channel restarts.
    int             edge_n = 0;
    int             m_shd  [NCH];
    int             m_act  [NCH];
    int             m_next [NCH];
    logic [NCH-1:0] m_arm;
    logic [NCH-1:0] m_ce;
    logic [NCH-1:0] m_done;

    always @(posedge clock) begin
        edge_n++;
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                m_shd[i]  = RDIV;
                m_act[i]  = RDIV;
                m_arm[i]  = 1'b1;
                m_done[i] = 1'b0;
                m_ce[i]   = 1'b0;
                m_next[i] = edge_n + RDIV + 1;
            end else begin
                bit hit;
                int ld;
                hit = div_wr && (int'(div_sel) == i);
                ld  = hit ? int'(div_data) : m_shd[i];
                if (hit) m_shd[i] = int'(div_data);
                m_ce[i] = 1'b0;
                if (sync || !run[i]) begin
                    m_act[i]  = ld;
                    m_arm[i]  = 1'b1;
                    m_done[i] = 1'b0;
                    m_next[i] = edge_n + ld + 1;
                end else if (m_arm[i] && edge_n == m_next[i]) begin
                    m_ce[i]   = 1'b1;
                    m_act[i]  = ld;
                    m_next[i] = edge_n + ld + 1;
                    if (oneshot[i]) begin
                        m_arm[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Compare the DUT outputs with the model on every cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            checks++;
            if (clocken !== m_ce) begin
                failures++;
                $display("FAIL model_clocken edge=%0d actual=%b required=%b", edge_n, clocken, m_ce);
            end
            checks++;
            if (done !== m_done) begin
                failures++;
                $display("FAIL model_done edge=%0d actual=%b required=%b", edge_n, done, m_done);
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input int sel, input int data);
        div_wr   = 1'b1;
        div_sel  = SELW'(sel);
        div_data = DIVW'(data);
        tick(1);
        div_wr   = 1'b0;
    endtask

    // Count edges up to the next pulse on channel ch. The wait is bounded, and -1 means the pulse never came.
    task automatic wait_pulse(input int ch, input int start, input int expected, input string name);
        int k;
        bit seen;
        k    = start;
        seen = 1'b0;
        while (!seen && k < start + 64) begin
            tick(1);
            k++;
            if (clocken[ch]) seen = 1'b1;
        end
        chk(name, seen ? k : -1, expected);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int first [NCH];
        int cnt   [NCH];
        int k;

        reset    = 1'b1;
        run      = '0;
        oneshot  = '0;
        sync     = 1'b0;
        div_wr   = 1'b0;
        div_sel  = '0;
        div_data = '0;
        tick(2);
        chk("reset_clocken", int'(clocken), 0);
        chk("reset_done", int'(done), 0);
        chk_en = 1'b1;
        reset  = 1'b0;

        // Channel 0 alone at the reset divisor of 4 pulses every 5 edges.
        run = 4'b0001;
        wait_pulse(0, 0, 5, "ch0_pulse1");
        chk("ch0_others_quiet", int'(clocken[3:1]), 0);
        wait_pulse(0, 0, 5, "ch0_pulse2");
        wait_pulse(0, 0, 5, "ch0_pulse3");

        // Write divisor 2 when cnt=1. The current period stays 5 edges and the following periods are 3 edges.
        tick(1);
        wr(0, 2);
        wait_pulse(0, 2, 5, "divchg_finish_period");
        wait_pulse(0, 0, 3, "divchg_new_period1");
        wait_pulse(0, 0, 3, "divchg_new_period2");
        run = '0;
        tick(1);

        // Divisors 1,2,3,4 with all channels running. After sync the first pulses come 2,3,4,5 edges later.
        wr(0, 1);
        wr(1, 2);
        wr(2, 3);
        wr(3, 4);
        run = 4'b1111;
        tick(7);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        chk("sync_clears_clocken", int'(clocken), 0);
        for (int i = 0; i < NCH; i++) first[i] = 0;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            for (int i = 0; i < NCH; i++)
                if (clocken[i] && first[i] == 0) first[i] = c;
        end
        chk("sync_first_ch0", first[0], 2);
        chk("sync_first_ch1", first[1], 3);
        chk("sync_first_ch2", first[2], 4);
        chk("sync_first_ch3", first[3], 5);
        run = '0;
        tick(1);

        // Oneshot on channel 1 at divisor 3 gives one pulse, and dropping run re-arms it.
        wr(1, 3);
        oneshot = 4'b0010;
        run     = 4'b0010;
        wait_pulse(1, 0, 4, "oneshot_first_pulse");
        chk("oneshot_done_set", int'(done[1]), 1);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (clocken[1]) k++;
        end
        chk("oneshot_no_repeat", k, 0);
        chk("oneshot_done_held", int'(done[1]), 1);
        run = '0;
        tick(1);
        chk("oneshot_done_cleared", int'(done[1]), 0);
        run = 4'b0010;
        wait_pulse(1, 0, 4, "oneshot_rearm_pulse");
        chk("oneshot_done_again", int'(done[1]), 1);
        run     = '0;
        oneshot = '0;
        tick(1);

        // An out-of-range select is ignored. Divisor 0 on channel 2 pulses on every edge.
        wr(5, 7);
        wr(2, 0);
        run = 4'b0111;
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            for (int i = 0; i < NCH; i++)
                if (clocken[i]) cnt[i]++;
        end
        chk("badsel_ch0_count", cnt[0], 6);
        chk("badsel_ch1_count", cnt[1], 3);
        chk("div0_ch2_count", cnt[2], 12);
        chk("badsel_ch3_count", cnt[3], 0);
        run = '0;
        tick(1);

        // Reset mid-count after a divisor write restores divisor 4 and a full first period.
        run = 4'b0001;
        tick(3);
        wr(0, 9);
        reset = 1'b1;
        tick(1);
        chk("midreset_clocken", int'(clocken), 0);
        chk("midreset_done", int'(done), 0);
        reset = 1'b0;
        wait_pulse(0, 0, 5, "midreset_period1");
        wait_pulse(0, 0, 5, "midreset_period2");
        run = '0;
        tick(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_clockgen.md
PROG_CLOCKGEN -- requirements
Module: prog_clockgen

Interface
REQ-001 Parameter NCH, default 4: number of independent clock-enable channels (1..16).
REQ-002 Parameter DIVW, default 18: divisor/counter width in bits.
REQ-003 Parameter SELW, default 2: width of div_sel; 2**SELW SHALL be >= NCH.
REQ-004 Parameter RESET_DIV, default 200000: divisor loaded into every channel at reset (100 MHz -> ~500 Hz).
REQ-005 clock  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high; sampled only on the rising edge of clock.
REQ-007 run  input  NCH  per-channel run; 1 = count, 0 = hold counter cleared.
REQ-008 oneshot  input  NCH  per-channel mode; 0 = continuous, 1 = single pulse per run assertion.
REQ-009 sync  input  1  one-cycle strobe that restarts all channels phase-aligned.
REQ-010 div_wr  input  1  divisor write strobe.
REQ-011 div_sel  input  SELW  channel index for div_wr.
REQ-012 div_data  input  DIVW  divisor value for div_wr.
REQ-013 clocken  output  NCH  per-channel registered one-cycle enable pulse.
REQ-014 done  output  NCH  per-channel registered flag: oneshot pulse has been issued.

Function
REQ-015 Each channel SHALL hold cnt[DIVW], div_active[DIVW], div_shadow[DIVW] and an armed bit.
REQ-016 Channel period SHALL be div_active+1 clock cycles; div_active=0 gives clocken high every cycle while running.
REQ-017 Per edge with run_i=1 and armed_i=1: if cnt==div_active, then cnt<=0, clocken_i<=1, div_active<=div_shadow; else cnt<=cnt+1, clocken_i<=0.
REQ-018 First pulse SHALL be registered on the (div_active+1)-th edge that samples run_i=1, counting from the first such edge.
REQ-019 Per edge with run_i=0: cnt<=0, clocken_i<=0, div_active<=div_shadow, armed_i<=1, done_i<=0.
REQ-020 div_wr with div_sel<NCH SHALL write div_data into div_shadow of the selected channel only; div_sel>=NCH SHALL be ignored.
REQ-021 A new divisor SHALL take effect at the next terminal count, or immediately while the channel is stopped; the running period is never truncated.
REQ-022 div_wr coinciding with the terminal count of the selected channel SHALL make div_data the div_active value loaded at that edge.
REQ-023 In oneshot mode, on the edge that registers the pulse: armed_i<=0, done_i<=1; while armed_i=0 the counter SHALL hold at 0 and clocken_i SHALL stay 0.
REQ-024 Toggling oneshot_i while running SHALL take effect at the next terminal count.
REQ-025 sync=1 SHALL set every cnt to 0, clear every clocken, set div_active<=div_shadow, set armed<=1 and clear done on all channels in the same edge.
REQ-026 div_wr together with sync SHALL load div_data directly into both div_shadow and div_active of the selected channel.
REQ-027 Priority SHALL be reset > sync > per-channel run/count logic.
REQ-028 Counter wrap beyond 2**DIVW-1 SHALL never occur, because cnt never exceeds div_active.

Reset
REQ-029 On an edge with reset=1, the block SHALL set cnt<=0, div_active<=RESET_DIV, div_shadow<=RESET_DIV, armed<=1, clocken<=0 and done<=0 on all channels.
REQ-030 Reset asserted mid-period SHALL discard the partial count; the next period SHALL be full length.
REQ-031 Inputs other than clock SHALL be ignored while reset=1.

Verification (NCH=4, DIVW=8, RESET_DIV=4)
REQ-032 Bench SHALL cover: reset, then run=4'b0001 -> clocken[0] pulses on edges 5, 10, 15 after run is sampled; the other channels stay 0.
REQ-033 Bench SHALL cover: ch0 running at div 4, div_wr sel=0 data=2 at cnt=1 -> current period finishes at 5 cycles, subsequent periods are 3 cycles.
REQ-034 Bench SHALL cover: run=4'b1111 with divisors 1, 2, 3, 4 and a sync strobe -> all cnt=0, then the first pulses arrive 2, 3, 4, 5 edges after sync.
REQ-035 Bench SHALL cover: oneshot[1]=1, run[1]=1, div 3 -> exactly one pulse on edge 4 and done[1]=1; drop and re-raise run[1] -> done[1]=0, then one new pulse.
REQ-036 Bench SHALL cover: div_wr sel=5 data=7 -> no div_shadow changes; div 0 on ch2 -> clocken[2] is constantly 1 while running.
REQ-037 Bench SHALL cover: reset mid-count with a div_wr issued before it -> divisor returns to 4 and clocken=0 for 5 edges.
